tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Multi-channel timeout scheduler built around one shared clock prescaler. The prescaler divides the 50 MHz system clock into a one-cycle `tick` enable. Each of N_CH channels can be loaded with a tick count and reports busy and done. Lab timing consumers (blinkers, debouncers, display refresh) request delays from this block instead of each instantiating its own wide divider counter.

## Interface
- CLK_DIV, 25_000_000: clk cycles per tick; legal range 2 to 2^32-1.
- N_CH, 4: number of independent channels.
- CNT_W, 8: width of each channel's tick counter.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- pause  in  1  freezes the prescaler and all channel counters while high.
- start  in  N_CH  per-channel load strobe, sampled on posedge clk.
- load_val  in  N_CH*CNT_W  channel i uses bits [i*CNT_W +: CNT_W]; number of ticks to wait.
- busy  out  N_CH  channel is counting.
- done  out  N_CH  one-cycle pulse when the channel expires.
- tick  out  1  one-cycle pulse at each prescaler wrap.
- sq_clk  out  1  square wave toggled on every tick (see Configuration).

## Operation
- Prescaler: 32-bit counter `pcnt` runs 0 to CLK_DIV-1, then wraps to 0.
  - `tick` = (pcnt == CLK_DIV-1) && !pause.
  - pcnt holds while pause is high.
- Each channel has FSM state CH_IDLE or CH_RUN, plus counter `cnt[CNT_W]`.
- CH_IDLE:
  - start with load_val == 0: done pulses next cycle; state stays CH_IDLE.
  - start with load_val != 0: cnt <= load_val, go to CH_RUN.
- CH_RUN, priority order:
  - start is present: reload (restart). A new load_val == 0 gives done next cycle and returns to CH_IDLE. No done for the aborted run.
  - Else, tick with cnt == 1: go to CH_IDLE, done pulse.
  - Else, tick: cnt <= cnt - 1.
- Start that coincides with tick: start wins; that tick is not applied to the new count.
- Channels are fully independent. Simultaneous starts on any subset are all accepted.
- pause high: no tick is generated, so no channel decrements. start and reload are still honoured.
- Unsigned arithmetic. cnt never underflows, because the cnt == 1 check precedes any decrement.

## Timing
- All outputs are registered except `tick` and `busy`:
  - `tick` is combinational from pcnt and pause.
  - `busy` = (state == CH_RUN).
- Reset values: pcnt 0, all states CH_IDLE, cnt 0, busy 0, done 0, tick 0, sq_clk 1.
- busy rises in the cycle after start is sampled.
- done latency:
  - Loaded with N > 0 at edge t: done is high in the cycle following the edge that samples the N-th tick after t. busy falls in that same cycle.
- Reset asserted mid-run: everything returns to reset values at the next edge. No done pulse.
- First tick after reset occurs CLK_DIV cycles after reset deasserts.

## Configuration
- Macro `TICK_SCHED_SQUARE_EN`.
- Defined: sq_clk resets to 1 and inverts on every cycle where tick is high. This gives a 50% duty square wave at clk/(2*CLK_DIV), i.e. 1 Hz for the default on 50 MHz.
- Undefined: sq_clk is tied to 0 and its flop is not synthesized.

## Structure
- Package `tick_sched_pkg` holds:
  - `typedef enum logic {CH_IDLE, CH_RUN} ch_state_t`.
  - `localparam int DEFAULT_CLK_DIV = 25_000_000`.
  - `localparam int PRESC_W = 32`.
- Sub-module `tick_prescaler` contains pcnt, the tick generation and the optional sq_clk flop. Ports: clk, reset, pause, tick, sq_clk; parameter CLK_DIV.
- Top level instantiates `tick_prescaler` once plus a generate loop of N_CH channel FSMs.

## Test plan
All scenarios use CLK_DIV=4, N_CH=4, CNT_W=8.
- Reset held 3 cycles: busy=0, done=0, tick=0, sq_clk=1 (macro on). First tick occurs 4 cycles after release, then every 4 cycles. sq_clk toggles on each tick.
- start[0] with load 3: busy[0]=1 for three ticks. done[0] pulses exactly once, in the cycle after the edge sampling the 3rd tick. busy[0] falls in the same cycle.
- start[1] with load 0: done[1] pulses the next cycle; busy[1] never asserts.
- start[2] with load 5, then restart with load 2 after 2 ticks: no done from the first run. done[2] fires after 2 further ticks.
- pause high for 10 cycles during a load-4 run on ch3: tick stays 0 and ch3 does not decrement. Expiry is delayed by exactly 10 cycles.
- All four channels started together with loads 1, 2, 3, 4, with the start edge coinciding with a tick: that tick is ignored. done pulses on the 1st, 2nd, 3rd and 4th subsequent ticks respectively.

Source files
------------

// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: channel state encoding,
// default prescaler divide ratio and prescaler counter width.
package tick_sched_pkg;

   typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

   localparam int DEFAULT_CLK_DIV = 25_000_000;
   localparam int PRESC_W         = 32;

endpackage : tick_sched_pkg

// File: rtl/tick_prescaler.sv
// Shared clock prescaler producing a one-cycle tick enable every CLK_DIV cycles.
// Optional square-wave output enabled by macro TICK_SCHED_SQUARE_EN.
module tick_prescaler
   import tick_sched_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic pause,
   output logic tick,
   output logic sq_clk
);

   localparam logic [PRESC_W-1:0] LAST_S = PRESC_W'(CLK_DIV - 1);
   localparam logic [PRESC_W-1:0] ONE_S  = PRESC_W'(1);

   logic [PRESC_W-1:0] pcnt_r;

   assign tick = (pcnt_r == LAST_S) && !pause;

   // Divider counter: holds while paused, wraps on the tick cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt_r <= {PRESC_W{1'b0}};
      end else if (pause) begin
         pcnt_r <= pcnt_r;
      end else if (tick) begin
         pcnt_r <= {PRESC_W{1'b0}};
      end else begin
         pcnt_r <= pcnt_r + ONE_S;
      end
   end

`ifdef TICK_SCHED_SQUARE_EN
   logic sq_r;

   // Square wave: inverts once per tick, giving clk/(2*CLK_DIV).
   always_ff @(posedge clk) begin
      if (reset) begin
         sq_r <= 1'b1;
      end else if (tick) begin
         sq_r <= ~sq_r;
      end else begin
         sq_r <= sq_r;
      end
   end

   assign sq_clk = sq_r;
`else
   assign sq_clk = 1'b0;
`endif

endmodule : tick_prescaler

// File: rtl/tick_scheduler.sv
// Multi-channel timeout scheduler: one shared prescaler, N_CH independent
// tick-count channels. Square-wave output controlled by TICK_SCHED_SQUARE_EN.
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
   parameter int          N_CH    = 4,
   parameter int          CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pause,
   input  logic [N_CH-1:0]       start,
   input  logic [N_CH*CNT_W-1:0] load_val,
   output logic [N_CH-1:0]       busy,
   output logic [N_CH-1:0]       done,
   output logic                  tick,
   output logic                  sq_clk
);

   localparam logic [CNT_W-1:0] ZERO_S = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_S  = CNT_W'(1);

   tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_presc (
      .clk    (clk),
      .reset  (reset),
      .pause  (pause),
      .tick   (tick),
      .sq_clk (sq_clk)
   );

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      ch_state_t        state_r;
      logic [CNT_W-1:0] cnt_r;
      logic             done_r;
      logic [CNT_W-1:0] ld_s;

      assign ld_s    = load_val[i*CNT_W +: CNT_W];
      assign busy[i] = (state_r == CH_RUN);
      assign done[i] = done_r;

      // Channel FSM: start (load/reload) has priority over a coincident tick.
      always_ff @(posedge clk) begin
         if (reset) begin
            state_r <= CH_IDLE;
            cnt_r   <= ZERO_S;
            done_r  <= 1'b0;
         end else begin
            done_r <= 1'b0;
            case (state_r)
               CH_IDLE: begin
                  if (start[i]) begin
                     if (ld_s == ZERO_S) begin
                        done_r <= 1'b1;
                     end else begin
                        cnt_r   <= ld_s;
                        state_r <= CH_RUN;
                     end
                  end
               end
               CH_RUN: begin
                  if (start[i]) begin
                     if (ld_s == ZERO_S) begin
                        done_r  <= 1'b1;
                        cnt_r   <= ZERO_S;
                        state_r <= CH_IDLE;
                     end else begin
                        cnt_r <= ld_s;
                     end
                  end else if (tick) begin
                     if (cnt_r == ONE_S) begin
                        done_r  <= 1'b1;
                        cnt_r   <= ZERO_S;
                        state_r <= CH_IDLE;
                     end else begin
                        cnt_r <= cnt_r - ONE_S;
                     end
                  end
               end
               default: begin
                  state_r <= CH_IDLE;
                  cnt_r   <= ZERO_S;
               end
            endcase
         end
      end
   end

endmodule : tick_scheduler

// File: tb/tb_tick_scheduler.sv
// Directed self-checking bench for tick_scheduler with CLK_DIV=4, N_CH=4, CNT_W=8.
module tb_tick_scheduler;

   logic        clk;
   logic        reset;
   logic        pause;
   logic [3:0]  start;
   logic [31:0] load_val;
   logic [3:0]  busy;
   logic [3:0]  done;
   logic        tick;
   logic        sq_clk;

   int nvec;
   int nerr;
   int exp_pcnt;

   tick_scheduler #(
      .CLK_DIV (4),
      .N_CH    (4),
      .CNT_W   (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .pause    (pause),
      .start    (start),
      .load_val (load_val),
      .busy     (busy),
      .done     (done),
      .tick     (tick),
      .sq_clk   (sq_clk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: track the expected prescaler phase, then check tick #1 after the edge.
   task automatic step();
      logic p;
      logic r;
      p = pause;
      r = reset;
      @(posedge clk);
      if (r) exp_pcnt = 0;
      else if (!p) exp_pcnt = (exp_pcnt == 3) ? 0 : exp_pcnt + 1;
      #1;
      chk("tick", 32'(tick), 32'(exp_pcnt == 3 && !pause));
   endtask

   task automatic align(input int phase);
      for (int k = 0; k < 8 && exp_pcnt != phase; k++) step();
      chk("align", 32'(exp_pcnt), 32'(phase));
   endtask

   initial begin
      nvec = 0; nerr = 0; exp_pcnt = 0;
      reset = 1'b1; pause = 1'b0; start = 4'b0000; load_val = 32'h0;

      for (int k = 0; k < 3; k++) step();
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
`ifdef TICK_SCHED_SQUARE_EN
      chk("rst_sq", 32'(sq_clk), 32'h1);
`else
      chk("rst_sq", 32'(sq_clk), 32'h0);
`endif
      reset = 1'b0;

      // Tick lands in the 4th cycle after release, then every 4 cycles.
      for (int k = 1; k <= 12; k++) begin
         step();
         chk("first_tick", 32'(tick), 32'((k % 4) == 3));
`ifdef TICK_SCHED_SQUARE_EN
         chk("sq_clk", 32'(sq_clk), 32'(((k / 4) % 2) == 0));
`else
         chk("sq_clk", 32'(sq_clk), 32'h0);
`endif
      end

      // Channel 0, load 3: third tick consumed 11 edges after start.
      align(0);
      start = 4'b0001; load_val = 32'h0000_0003;
      step();
      start = 4'b0000;
      chk("c0_busy_rise", 32'(busy[0]), 32'h1);
      for (int j = 1; j <= 13; j++) begin
         step();
         chk("c0_done", 32'(done[0]), 32'(j == 11));
         chk("c0_busy", 32'(busy[0]), 32'(j < 11));
      end

      // Channel 1, load 0: immediate done, never busy.
      start = 4'b0010; load_val = 32'h0000_0000;
      step();
      start = 4'b0000;
      chk("c1_done", 32'(done[1]), 32'h1);
      chk("c1_busy", 32'(busy[1]), 32'h0);
      step();
      chk("c1_done_end", 32'(done[1]), 32'h0);
      chk("c1_busy_end", 32'(busy[1]), 32'h0);

      // Channel 2: load 5, restart with 2 after two ticks; only the second run completes.
      align(0);
      start = 4'b0100; load_val = 32'h0005_0000;
      step();
      start = 4'b0000;
      for (int j = 1; j <= 20; j++) begin
         step();
         if (j == 7) begin
            start = 4'b0100; load_val = 32'h0002_0000;
         end else begin
            start = 4'b0000;
         end
         chk("c2_done", 32'(done[2]), 32'(j == 15));
         chk("c2_busy", 32'(busy[2]), 32'(j < 15));
      end

      // Channel 3, load 4 with a 10-cycle pause: expiry moves from edge 15 to 25.
      align(0);
      start = 4'b1000; load_val = 32'h0400_0000;
      step();
      start = 4'b0000;
      for (int j = 1; j <= 27; j++) begin
         step();
         if (pause) chk("pause_tick", 32'(tick), 32'h0);
         chk("c3_done", 32'(done[3]), 32'(j == 25));
         chk("c3_busy", 32'(busy[3]), 32'(j < 25));
         if (j == 4) pause = 1'b1;
         else if (j == 14) pause = 1'b0;
      end

      // All channels started on a tick edge: that tick is ignored.
      align(3);
      chk("f_tick_at_start", 32'(tick), 32'h1);
      start = 4'b1111; load_val = 32'h0403_0201;
      step();
      start = 4'b0000;
      chk("f_busy_rise", 32'(busy), 32'hF);
      for (int j = 1; j <= 18; j++) begin
         logic [3:0] exp_done;
         logic [3:0] exp_busy;
         step();
         for (int i = 0; i < 4; i++) begin
            exp_done[i] = (j == 4 * (i + 1));
            exp_busy[i] = (j < 4 * (i + 1));
         end
         chk("f_done", 32'(done), 32'(exp_done));
         chk("f_busy", 32'(busy), 32'(exp_busy));
      end

      // Reset mid-run: channel returns idle with no done pulse.
      start = 4'b0001; load_val = 32'h0000_0009;
      step();
      start = 4'b0000;
      chk("mr_busy", 32'(busy[0]), 32'h1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mr_busy_clr", 32'(busy), 32'h0);
      chk("mr_done_clr", 32'(done), 32'h0);
      step();
      chk("mr_done_after", 32'(done), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule : tb_tick_scheduler
